// File: rtl/hamming_count16_if.sv
// Handshake/data bundle between the XOR stage driver and hamming_count16.
// The parity signal exists only when HC_PARITY_OUT_EN is defined.
interface hamming_count16_if;
   logic        start;
   logic [15:0] din;
   logic        ready;
   logic        busy;
   logic        done;
   logic [4:0]  count;
`ifdef HC_PARITY_OUT_EN
   logic        parity;
`endif

   modport master (
      output start,
      output din,
      input  ready,
      input  busy,
      input  done,
      input  count
`ifdef HC_PARITY_OUT_EN
      , input parity
`endif
   );

   modport slave (
      input  start,
      input  din,
      output ready,
      output busy,
      output done,
      output count
`ifdef HC_PARITY_OUT_EN
      , output parity
`endif
   );
endinterface

// File: rtl/hamming_count16.sv
// Bit-serial Hamming-weight counter: captures a 16-bit XOR result and counts its set bits
// one per clock. Optional registered parity output when HC_PARITY_OUT_EN is defined.
module hamming_count16 (
   input  logic               clk,
   input  logic               rst,
   hamming_count16_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [15:0] sr;
   logic [3:0]  idx;
   logic [4:0]  acc;
   logic        load;
   logic        shift_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DONE accepts a new start directly so back-to-back runs lose no cycle.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (idx == 4'd15) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Always 16 shifts, even once sr has drained, so latency is data independent.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr  <= 16'd0;
         idx <= 4'd0;
         acc <= 5'd0;
      end else if (load) begin
         sr  <= bus.din;
         idx <= 4'd0;
         acc <= 5'd0;
      end else if (shift_en) begin
         sr  <= {1'b0, sr[15:1]};
         idx <= idx + 4'd1;
         acc <= acc + {4'd0, sr[0]};
      end
   end

   assign bus.ready = (state_q == IDLE) || (state_q == DONE);
   assign bus.busy  = (state_q == SHIFT);
   assign bus.done  = (state_q == DONE);
   assign bus.count = acc;

`ifdef HC_PARITY_OUT_EN
   assign bus.parity = acc[0];
`endif

endmodule

// File: tb/tb_hamming_count16.sv
// Self-checking bench for hamming_count16: directed runs plus a per-cycle reference model.
// Build with HC_PARITY_OUT_EN defined to also check the parity output.
module tb_hamming_count16;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   hamming_count16_if bus ();

   hamming_count16 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: remaining shift cycles, adds completed, captured word, done flag.
   logic [15:0] m_cap;
   int          m_left;
   int          m_adds;
   logic        m_done;
   logic        m_valid;

   function automatic int prefix_ones(input logic [15:0] v, input int n);
      int c;
      c = 0;
      for (int i = 0; i < n; i++) begin
         if (v[i]) c++;
      end
      return c;
   endfunction

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   initial begin
      m_valid = 1'b0;
      m_cap   = 16'd0;
      m_left  = 0;
      m_adds  = 0;
      m_done  = 1'b0;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b1;
         m_cap   <= 16'd0;
         m_left  <= 0;
         m_adds  <= 0;
         m_done  <= 1'b0;
      end else if (m_left > 0) begin
         m_adds  <= m_adds + 1;
         m_left  <= m_left - 1;
         m_done  <= (m_left == 1);
      end else if (bus.start) begin
         m_cap   <= bus.din;
         m_adds  <= 0;
         m_left  <= 16;
         m_done  <= 1'b0;
      end else begin
         m_done  <= 1'b0;
      end
   end

   // Compare every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (m_valid) begin
         check_output("model_count", int'(bus.count), prefix_ones(m_cap, m_adds));
         check_output("model_ready", int'(bus.ready), int'(m_left == 0));
         check_output("model_busy",  int'(bus.busy),  int'(m_left > 0));
         check_output("model_done",  int'(bus.done),  int'(m_done));
`ifdef HC_PARITY_OUT_EN
         check_output("model_parity", int'(bus.parity), prefix_ones(m_cap, m_adds) % 2);
`endif
      end
   end

   task automatic apply_stimulus(input logic s, input logic [15:0] d);
      bus.start = s;
      bus.din   = d;
   endtask

   task automatic wait_done(output int lat, output int busy_n);
      lat    = 0;
      busy_n = 0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.busy) busy_n++;
      end while (!bus.done && lat < 40);
      if (!bus.done) begin
         checks++;
         failures++;
         $display("[TB] FAIL done_timeout actual=0 expected=1 at %0t", $time);
      end
   endtask

   task automatic run_one(input string name, input logic [15:0] d, input int exp_count);
      int lat;
      int busy_n;
      @(negedge clk);
      apply_stimulus(1'b1, d);
      @(negedge clk);
      apply_stimulus(1'b0, 16'h0000);
      lat    = 1;
      busy_n = bus.busy ? 1 : 0;
      if (!bus.done) begin
         int more_lat;
         int more_busy;
         wait_done(more_lat, more_busy);
         lat    += more_lat;
         busy_n += more_busy;
      end
      check_output({name, "_count"}, int'(bus.count), exp_count);
      check_output({name, "_latency"}, lat, 17);
      check_output({name, "_busy_cycles"}, busy_n, 16);
      @(negedge clk);
      check_output({name, "_done_width"}, int'(bus.done), 0);
      check_output({name, "_count_held"}, int'(bus.count), exp_count);
   endtask

   initial begin
      int lat;
      int busy_n;
      int done_seen;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      apply_stimulus(1'b0, 16'h0000);

      repeat (2) begin
         @(negedge clk);
         check_output("reset_count", int'(bus.count), 0);
         check_output("reset_ready", int'(bus.ready), 1);
         check_output("reset_busy",  int'(bus.busy),  0);
         check_output("reset_done",  int'(bus.done),  0);
`ifdef HC_PARITY_OUT_EN
         check_output("reset_parity", int'(bus.parity), 0);
`endif
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_output("idle_ready", int'(bus.ready), 1);

      run_one("zero", 16'h0000, 0);
      run_one("ones", 16'hFFFF, 16);
      run_one("a5a5", 16'hA5A5, 8);

      // Input isolation: din change and start pulse during SHIFT must be ignored.
      @(negedge clk);
      apply_stimulus(1'b1, 16'h0001);
      lat       = 0;
      done_seen = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) apply_stimulus(1'b0, 16'h0001);
         if (lat == 3) apply_stimulus(1'b1, 16'hFFFF);
         if (lat == 5) apply_stimulus(1'b0, 16'hFFFF);
      end while (!bus.done && lat < 40);
      check_output("isolate_latency", lat, 17);
      check_output("isolate_count", int'(bus.count), 1);
      repeat (3) begin
         @(negedge clk);
         if (bus.done || bus.busy) done_seen++;
      end
      check_output("isolate_no_restart", done_seen, 0);

      // Back-to-back with start held high.
      @(negedge clk);
      apply_stimulus(1'b1, 16'h00FF);
      wait_done(lat, busy_n);
      check_output("b2b_first_latency", lat, 17);
      check_output("b2b_first_count", int'(bus.count), 8);
      apply_stimulus(1'b1, 16'h8001);
      @(negedge clk);
      check_output("b2b_restart_busy", int'(bus.busy), 1);
      check_output("b2b_restart_count", int'(bus.count), 0);
      wait_done(lat, busy_n);
      check_output("b2b_second_latency", lat + 1, 17);
      check_output("b2b_second_count", int'(bus.count), 2);
      apply_stimulus(1'b0, 16'h0000);
      @(negedge clk);
      check_output("b2b_idle_ready", int'(bus.ready), 1);

      // Reset in the middle of a run discards the partial count.
      @(negedge clk);
      apply_stimulus(1'b1, 16'hFFFF);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) apply_stimulus(1'b0, 16'h0000);
      end while (lat < 9);
      check_output("midrst_partial", int'(bus.count), 8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("midrst_count", int'(bus.count), 0);
      check_output("midrst_ready", int'(bus.ready), 1);
      check_output("midrst_busy",  int'(bus.busy),  0);
      done_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      check_output("midrst_no_done", done_seen, 0);
      run_one("after_rst", 16'h0003, 2);

      run_one("par7", 16'h0007, 3);
`ifdef HC_PARITY_OUT_EN
      check_output("par7_parity", int'(bus.parity), 1);
`endif
      run_one("parF", 16'h000F, 4);
`ifdef HC_PARITY_OUT_EN
      check_output("parF_parity", int'(bus.parity), 0);
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout actual=expired expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
